// File: rtl/dram_cmd_gate_pkg.sv
// Shared types and timing defaults for the per-rank DRAM command legality gate.
package dram_cmd_gate_pkg;

    localparam int BA_BITS       = 3;
    localparam int NUM_BANKS_DEF = 8;
    localparam int CNT_W         = 6;
    localparam int FAW_SLOTS     = 4;

    localparam int DEF_CYCLE_TRRD = 4;
    localparam int DEF_CYCLE_TFAW = 20;
    localparam int DEF_CYCLE_TCCD = 4;
    localparam int DEF_CYCLE_TWTR = 6;

    // Last command issued to a bank, as tracked by the per-bank state machines.
    typedef enum logic [2:0] {
        CODE_IDLE                 = 3'd0,
        CODE_PRECHARGE_TO_ACTIVE  = 3'd1,
        CODE_ACTIVE_TO_READ_WRITE = 3'd2,
        CODE_READ_TO_PRECHARGE    = 3'd3,
        CODE_WRITE_TO_PRECHARGE   = 3'd4,
        CODE_PRECHARGE_TO_REFRESH = 3'd5,
        CODE_REFRESH              = 3'd6
    } recode_state_t;

    typedef enum logic [2:0] {
        CMD_NOP   = 3'd0,
        CMD_ACT   = 3'd1,
        CMD_READ  = 3'd2,
        CMD_WRITE = 3'd3,
        CMD_PRE   = 3'd4,
        CMD_REF   = 3'd5
    } cmd_t;

    typedef enum logic [2:0] {
        RSN_NONE    = 3'd0,
        RSN_ILLEGAL = 3'd1,
        RSN_BANK    = 3'd2,
        RSN_RRD     = 3'd3,
        RSN_FAW     = 3'd4,
        RSN_CCD     = 3'd5,
        RSN_WTR     = 3'd6
    } reason_t;

    // Number of set bits in a 4-bit vector (0..4).
    function automatic logic [2:0] popcount4(input logic [3:0] v);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 4; i++) begin
            c = c + {2'b00, v[i]};
        end
        return c;
    endfunction

endpackage

// File: rtl/dram_cmd_gate_faw_window.sv
// Rolling tFAW window: four slot down-counters, a lowest-free-slot allocator
// and a registered count of busy slots that is always in step with the slots.
module dram_cmd_gate_faw_window
    import dram_cmd_gate_pkg::*;
#(
    parameter int CYCLE_TFAW = DEF_CYCLE_TFAW
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    output logic [2:0] count
);

    logic [FAW_SLOTS-1:0][CNT_W-1:0] slot_r;
    logic [FAW_SLOTS-1:0][CNT_W-1:0] slot_nxt_s;
    logic [FAW_SLOTS-1:0]            busy_nxt_s;
    logic                            found_s;
    logic [2:0]                      count_r;

    // Next slot values: busy slots tick down, a load claims the lowest free slot.
    always_comb begin
        slot_nxt_s = slot_r;
        busy_nxt_s = '0;
        found_s    = 1'b0;
        for (int i = 0; i < FAW_SLOTS; i++) begin
            if (load && !found_s && (slot_r[i] == 6'd0)) begin
                slot_nxt_s[i] = 6'(CYCLE_TFAW - 1);
                found_s       = 1'b1;
            end else if (slot_r[i] != 6'd0) begin
                slot_nxt_s[i] = slot_r[i] - 6'd1;
            end else begin
                slot_nxt_s[i] = slot_r[i];
            end
            busy_nxt_s[i] = (slot_nxt_s[i] != 6'd0);
        end
    end

    // Slot state and busy count are registered together so the count has no lag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_r  <= '0;
            count_r <= 3'd0;
        end else begin
            slot_r  <= slot_nxt_s;
            count_r <= popcount4(busy_nxt_s);
        end
    end

    assign count = count_r;

endmodule

// File: rtl/dram_cmd_gate.sv
// Per-rank command legality gate: merges per-bank timing state with the
// inter-bank tRRD / tFAW / tCCD / tWTR timers into one grant for the candidate.
module dram_cmd_gate
    import dram_cmd_gate_pkg::*;
#(
    parameter int NUM_BANKS  = NUM_BANKS_DEF,
    parameter int CYCLE_TRRD = DEF_CYCLE_TRRD,
    parameter int CYCLE_TFAW = DEF_CYCLE_TFAW,
    parameter int CYCLE_TCCD = DEF_CYCLE_TCCD,
    parameter int CYCLE_TWTR = DEF_CYCLE_TWTR
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            req_valid,
    input  logic [2:0]                      req_cmd,
    input  logic [BA_BITS-1:0]              req_bank,
    input  logic                            req_auto_pre,
    input  logic [NUM_BANKS*5-1:0]          tp_cnt,
    input  logic [NUM_BANKS*6-1:0]          tras_cnt,
    input  recode_state_t [NUM_BANKS-1:0]   bank_code,
    output logic                            cmd_grant,
    output logic [2:0]                      block_reason,
    output logic [2:0]                      act_in_window
);

    cmd_t          cmd_s;
    logic [4:0]    tp_b_s;
    logic [5:0]    tras_b_s;
    recode_state_t code_b_s;
    logic          ref_ok_s;
    logic          act_bank_ok_s;
    logic          rw_bank_ok_s;
    logic          pre_bank_ok_s;
    logic          faw_full_s;
    reason_t       reason_s;
    logic          grant_s;
    logic          issue_s;
    logic          act_issue_s;
    logic [2:0]    faw_count_s;
    logic [5:0]    rrd_cnt_r;
    logic [5:0]    ccd_cnt_r;
    logic [5:0]    wtr_cnt_r;
    reason_t       block_reason_r;
    logic          unused_s;

    // Auto-precharge does not change legality at this stage.
    assign unused_s = req_auto_pre;

    assign cmd_s    = cmd_t'(req_cmd);
    assign tp_b_s   = tp_cnt[int'(req_bank) * 5 +: 5];
    assign tras_b_s = tras_cnt[int'(req_bank) * 6 +: 6];
    assign code_b_s = bank_code[req_bank];

    assign act_bank_ok_s = (tp_b_s == 5'd0) && (tras_b_s == 6'd0) &&
                           ((code_b_s == CODE_IDLE) || (code_b_s == CODE_PRECHARGE_TO_ACTIVE));
    assign rw_bank_ok_s  = (tp_b_s == 5'd0) &&
                           ((code_b_s == CODE_ACTIVE_TO_READ_WRITE) ||
                            (code_b_s == CODE_READ_TO_PRECHARGE) ||
                            (code_b_s == CODE_WRITE_TO_PRECHARGE));
    assign pre_bank_ok_s = (tp_b_s == 5'd0) && (tras_b_s == 6'd0);
    assign faw_full_s    = (faw_count_s >= 3'd4);

    // Refresh needs every bank quiet and either idle or precharged for refresh.
    always_comb begin
        ref_ok_s = 1'b1;
        for (int b = 0; b < NUM_BANKS; b++) begin
            ref_ok_s = ref_ok_s & (tp_cnt[b * 5 +: 5] == 5'd0) &
                       ((bank_code[b] == CODE_IDLE) || (bank_code[b] == CODE_PRECHARGE_TO_REFRESH));
        end
    end

    // Highest-priority reason the candidate is illegal; RSN_NONE means grant.
    always_comb begin
        reason_s = RSN_NONE;
        case (cmd_s)
            CMD_NOP: reason_s = RSN_NONE;
            CMD_ACT: begin
                if (!act_bank_ok_s)            reason_s = RSN_BANK;
                else if (rrd_cnt_r != 6'd0)    reason_s = RSN_RRD;
                else if (faw_full_s)           reason_s = RSN_FAW;
                else                           reason_s = RSN_NONE;
            end
            CMD_READ: begin
                if (!rw_bank_ok_s)             reason_s = RSN_BANK;
                else if (ccd_cnt_r != 6'd0)    reason_s = RSN_CCD;
                else if (wtr_cnt_r != 6'd0)    reason_s = RSN_WTR;
                else                           reason_s = RSN_NONE;
            end
            CMD_WRITE: begin
                if (!rw_bank_ok_s)             reason_s = RSN_BANK;
                else if (ccd_cnt_r != 6'd0)    reason_s = RSN_CCD;
                else                           reason_s = RSN_NONE;
            end
            CMD_PRE: begin
                if (!pre_bank_ok_s)            reason_s = RSN_BANK;
                else                           reason_s = RSN_NONE;
            end
            CMD_REF: begin
                if (!ref_ok_s)                 reason_s = RSN_BANK;
                else                           reason_s = RSN_NONE;
            end
            default: reason_s = RSN_ILLEGAL;
        endcase
    end

    // Grant is independent of req_valid so the scheduler FSM sees no loop.
    assign grant_s     = (reason_s == RSN_NONE);
    assign issue_s     = req_valid & grant_s;
    assign act_issue_s = issue_s && (cmd_s == CMD_ACT);

    // Inter-bank timers: a load on issue wins over the per-cycle decrement.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rrd_cnt_r <= 6'd0;
            ccd_cnt_r <= 6'd0;
            wtr_cnt_r <= 6'd0;
        end else begin
            if (act_issue_s)               rrd_cnt_r <= 6'(CYCLE_TRRD - 1);
            else if (rrd_cnt_r != 6'd0)    rrd_cnt_r <= rrd_cnt_r - 6'd1;
            else                           rrd_cnt_r <= rrd_cnt_r;

            if (issue_s && ((cmd_s == CMD_READ) || (cmd_s == CMD_WRITE)))
                                           ccd_cnt_r <= 6'(CYCLE_TCCD - 1);
            else if (ccd_cnt_r != 6'd0)    ccd_cnt_r <= ccd_cnt_r - 6'd1;
            else                           ccd_cnt_r <= ccd_cnt_r;

            if (issue_s && (cmd_s == CMD_WRITE))
                                           wtr_cnt_r <= 6'(CYCLE_TWTR - 1);
            else if (wtr_cnt_r != 6'd0)    wtr_cnt_r <= wtr_cnt_r - 6'd1;
            else                           wtr_cnt_r <= wtr_cnt_r;
        end
    end

    // Remember why the most recent valid request was refused.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block_reason_r <= RSN_NONE;
        end else if (req_valid && !grant_s) begin
            block_reason_r <= reason_s;
        end else begin
            block_reason_r <= block_reason_r;
        end
    end

    dram_cmd_gate_faw_window #(
        .CYCLE_TFAW (CYCLE_TFAW)
    ) u_faw (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (act_issue_s),
        .count (faw_count_s)
    );

    assign cmd_grant     = grant_s;
    assign block_reason  = block_reason_r;
    assign act_in_window = faw_count_s;

endmodule

// File: tb/tb_dram_cmd_gate.sv
// Directed bench for dram_cmd_gate: each scenario task drives a short cycle
// sequence and compares grant / reason / window count against hand-derived values.
module tb_dram_cmd_gate;
    import dram_cmd_gate_pkg::*;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 req_valid;
    logic [2:0]           req_cmd;
    logic [2:0]           req_bank;
    logic                 req_auto_pre;
    logic [39:0]          tp_cnt;
    logic [47:0]          tras_cnt;
    recode_state_t [7:0]  bank_code;
    logic                 cmd_grant;
    logic [2:0]           block_reason;
    logic [2:0]           act_in_window;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dram_cmd_gate dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_cmd       (req_cmd),
        .req_bank      (req_bank),
        .req_auto_pre  (req_auto_pre),
        .tp_cnt        (tp_cnt),
        .tras_cnt      (tras_cnt),
        .bank_code     (bank_code),
        .cmd_grant     (cmd_grant),
        .block_reason  (block_reason),
        .act_in_window (act_in_window)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        req_valid = 1'b0;
        req_cmd   = CMD_NOP;
        repeat (n) tick();
    endtask

    task automatic set_codes(input recode_state_t c);
        for (int b = 0; b < 8; b++) bank_code[b] = c;
    endtask

    task automatic req(input cmd_t c, input int bank);
        req_valid = 1'b1;
        req_cmd   = c;
        req_bank  = 3'(bank);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0; req_cmd = CMD_ACT; req_bank = 3'd0; req_auto_pre = 1'b0;
        tp_cnt = '0; tras_cnt = '0; set_codes(CODE_IDLE);
        tick(); tick();
        settle();
        total++; if (block_reason !== 3'd0) begin bad++; $display("FAIL reset_reason: got %0d expected 0", block_reason); end
        total++; if (act_in_window !== 3'd0) begin bad++; $display("FAIL reset_window: got %0d expected 0", act_in_window); end
        total++; if (cmd_grant !== 1'b1) begin bad++; $display("FAIL reset_grant_act: got %0b expected 1", cmd_grant); end
        tick();
        rst_n = 1'b1;
        req(CMD_NOP, 0);
        settle();
        total++; if (cmd_grant !== 1'b1) begin bad++; $display("FAIL nop_grant: got %0b expected 1", cmd_grant); end
        req_cmd = 3'd6;
        #1;
        total++; if (cmd_grant !== 1'b0) begin bad++; $display("FAIL illegal6_grant: got %0b expected 0", cmd_grant); end
        tick();
        total++; if (block_reason !== 3'd1) begin bad++; $display("FAIL illegal6_reason: got %0d expected 1", block_reason); end
        idle(2);
    endtask

    task automatic test_rrd();
        logic exp;
        set_codes(CODE_IDLE);
        for (int t = 0; t <= 4; t++) begin
            req(CMD_ACT, (t == 0) ? 0 : 1);
            exp = (t == 0) || (t == 4);
            settle();
            total++; if (cmd_grant !== exp) begin bad++; $display("FAIL rrd_grant t=%0d: got %0b expected %0b", t, cmd_grant, exp); end
            tick();
            if (t == 1) begin
                total++; if (block_reason !== 3'd3) begin bad++; $display("FAIL rrd_reason: got %0d expected 3", block_reason); end
            end
        end
        total++; if (act_in_window !== 3'd2) begin bad++; $display("FAIL rrd_window: got %0d expected 2", act_in_window); end
        idle(25);
    endtask

    task automatic test_faw();
        logic       exp;
        logic [2:0] exp_win;
        set_codes(CODE_IDLE);
        for (int t = 0; t <= 20; t++) begin
            if ((t % 4 == 0) && (t <= 12)) begin
                req(CMD_ACT, t / 4);
                exp = 1'b1;
            end else if (t >= 16) begin
                req(CMD_ACT, 4);
                exp = (t == 20);
            end else begin
                req_valid = 1'b0;
                exp = 1'b0;
            end
            exp_win = (t == 20) ? 3'd3 : ((t + 3) / 4 > 4) ? 3'd4 : 3'((t + 3) / 4);
            settle();
            total++; if (act_in_window !== exp_win) begin bad++; $display("FAIL faw_window t=%0d: got %0d expected %0d", t, act_in_window, exp_win); end
            if (req_valid) begin
                total++; if (cmd_grant !== exp) begin bad++; $display("FAIL faw_grant t=%0d: got %0b expected %0b", t, cmd_grant, exp); end
            end
            tick();
            if (t >= 16 && t < 20) begin
                total++; if (block_reason !== 3'd4) begin bad++; $display("FAIL faw_reason t=%0d: got %0d expected 4", t, block_reason); end
            end
        end
        total++; if (act_in_window !== 3'd4) begin bad++; $display("FAIL faw_refill: got %0d expected 4", act_in_window); end
        idle(25);
    endtask

    task automatic test_wtr();
        logic       exp;
        logic [2:0] exp_rsn;
        set_codes(CODE_ACTIVE_TO_READ_WRITE);
        for (int t = 0; t <= 6; t++) begin
            if (t == 0) req(CMD_WRITE, 0);
            else        req(CMD_READ, 1);
            exp = (t == 0) || (t == 6);
            settle();
            total++; if (cmd_grant !== exp) begin bad++; $display("FAIL wtr_grant t=%0d: got %0b expected %0b", t, cmd_grant, exp); end
            tick();
            if (t >= 1 && t <= 5) begin
                exp_rsn = (t <= 3) ? 3'd5 : 3'd6;
                total++; if (block_reason !== exp_rsn) begin bad++; $display("FAIL wtr_reason t=%0d: got %0d expected %0d", t, block_reason, exp_rsn); end
            end
        end
        idle(10);
    endtask

    task automatic test_pre();
        logic exp;
        set_codes(CODE_ACTIVE_TO_READ_WRITE);
        for (int v = 5; v >= 0; v--) begin
            tras_cnt[17:12] = 6'(v);
            req(CMD_PRE, 2);
            exp = (v == 0);
            settle();
            total++; if (cmd_grant !== exp) begin bad++; $display("FAIL pre_grant tras=%0d: got %0b expected %0b", v, cmd_grant, exp); end
            tick();
            if (v == 5) begin
                total++; if (block_reason !== 3'd2) begin bad++; $display("FAIL pre_reason: got %0d expected 2", block_reason); end
            end
        end
        tras_cnt = '0;
        idle(5);
    endtask

    task automatic test_ref();
        req_valid = 1'b1; req_cmd = 3'd7; req_bank = 3'd0;
        settle();
        total++; if (cmd_grant !== 1'b0) begin bad++; $display("FAIL illegal7_grant: got %0b expected 0", cmd_grant); end
        tick();
        total++; if (block_reason !== 3'd1) begin bad++; $display("FAIL illegal7_reason: got %0d expected 1", block_reason); end
        set_codes(CODE_PRECHARGE_TO_REFRESH);
        bank_code[3] = CODE_ACTIVE_TO_READ_WRITE;
        req(CMD_REF, 0);
        settle();
        total++; if (cmd_grant !== 1'b0) begin bad++; $display("FAIL ref_open_grant: got %0b expected 0", cmd_grant); end
        tick();
        total++; if (block_reason !== 3'd2) begin bad++; $display("FAIL ref_reason: got %0d expected 2", block_reason); end
        bank_code[3] = CODE_PRECHARGE_TO_REFRESH;
        tp_cnt[29:25] = 5'd3;
        settle();
        total++; if (cmd_grant !== 1'b0) begin bad++; $display("FAIL ref_tp_grant: got %0b expected 0", cmd_grant); end
        tp_cnt = '0;
        #1;
        total++; if (cmd_grant !== 1'b1) begin bad++; $display("FAIL ref_grant: got %0b expected 1", cmd_grant); end
        tick();
        req_valid = 1'b0;
        req_cmd = CMD_READ; req_bank = 3'd0;
        set_codes(CODE_ACTIVE_TO_READ_WRITE);
        settle();
        total++; if (cmd_grant !== 1'b1) begin bad++; $display("FAIL ref_no_ccd: got %0b expected 1", cmd_grant); end
        total++; if (act_in_window !== 3'd0) begin bad++; $display("FAIL ref_window: got %0d expected 0", act_in_window); end
        req_cmd = CMD_ACT;
        set_codes(CODE_IDLE);
        #1;
        total++; if (cmd_grant !== 1'b1) begin bad++; $display("FAIL ref_no_rrd: got %0b expected 1", cmd_grant); end
        idle(25);
    endtask

    task automatic test_mid_reset();
        set_codes(CODE_IDLE);
        for (int t = 0; t <= 12; t++) begin
            req(CMD_ACT, t % 8);
            tick();
        end
        settle();
        total++; if (act_in_window !== 3'd4) begin bad++; $display("FAIL mid_window_pre: got %0d expected 4", act_in_window); end
        total++; if (cmd_grant !== 1'b0) begin bad++; $display("FAIL mid_grant_pre: got %0b expected 0", cmd_grant); end
        total++; if (block_reason !== 3'd3) begin bad++; $display("FAIL mid_reason_pre: got %0d expected 3", block_reason); end
        rst_n = 1'b0;
        #1;
        total++; if (act_in_window !== 3'd0) begin bad++; $display("FAIL mid_window_rst: got %0d expected 0", act_in_window); end
        total++; if (block_reason !== 3'd0) begin bad++; $display("FAIL mid_reason_rst: got %0d expected 0", block_reason); end
        tick();
        rst_n = 1'b1;
        settle();
        total++; if (cmd_grant !== 1'b1) begin bad++; $display("FAIL mid_grant_post: got %0b expected 1", cmd_grant); end
        tick();
        total++; if (act_in_window !== 3'd1) begin bad++; $display("FAIL mid_window_post: got %0d expected 1", act_in_window); end
        idle(2);
    endtask

    initial begin
        test_reset();
        test_rrd();
        test_faw();
        test_wtr();
        test_pre();
        test_ref();
        test_mid_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
